// File: rtl/chu_pad_pkg.sv
// Shared definitions for the CHU message padder: algorithm codes, FSM states
// and the pad/length word helpers.
package chu_pad_pkg;

  localparam logic [2:0] ALG_MD5    = 3'd0;
  localparam logic [2:0] ALG_SHA1   = 3'd1;
  localparam logic [2:0] ALG_SHA256 = 3'd2;
  localparam logic [2:0] ALG_SHA512 = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_PAD       = 3'd2,
    ST_EXTRA     = 3'd3,
    ST_EXTRA_PAD = 3'd4,
    ST_EMIT      = 3'd5
  } pad_state_e;

  // MD5 is little-endian, so its 0x80 marker byte sits in the LSB.
  function automatic logic [63:0] pad_word(input logic [2:0] alg, input int data_w);
    logic [63:0] w;
    if (alg == ALG_MD5) w = 64'h80;
    else                w = 64'd1 << (data_w - 1);
    return w;
  endfunction

  // Word i of the length field, counted from the first length slot.
  function automatic logic [63:0] len_word(input logic [2:0]   alg,
                                           input logic [127:0] len,
                                           input int           i,
                                           input int           data_w,
                                           input int           len_words);
    int sh;
    sh = (alg == ALG_MD5) ? i * data_w : (len_words - 1 - i) * data_w;
    return 64'(len >> sh);
  endfunction

endpackage

// File: rtl/chu_pad_blk_reg.sv
// Block register file: BLOCK_WORDS words with per-word write enable and
// filled flag; a write to a word wins over a simultaneous clear.
module chu_pad_blk_reg #(
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [BLOCK_WORDS-1:0]        we_i,
  input  logic [BLOCK_WORDS*DATA_W-1:0] wdata_i,
  input  logic                          clr_i,
  output logic [BLOCK_WORDS*DATA_W-1:0] data_o,
  output logic [BLOCK_WORDS-1:0]        val_o
);

  logic [BLOCK_WORDS*DATA_W-1:0] data_q;
  logic [BLOCK_WORDS-1:0]        val_q;

  // NOTE: this storage is reset on purpose -- the block is a visible output
  // that must read all-zero after reset, unlike a RAM that nobody observes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      val_q  <= '0;
    end else begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        if (we_i[i]) begin
          data_q[i*DATA_W +: DATA_W] <= wdata_i[i*DATA_W +: DATA_W];
          val_q[i]                   <= 1'b1;
        end else if (clr_i) begin
          data_q[i*DATA_W +: DATA_W] <= '0;
          val_q[i]                   <= 1'b0;
        end
      end
    end
  end

  assign data_o = data_q;
  assign val_o  = val_q;

endmodule

// File: rtl/chu_pad_gen.sv
// CHU message padder: assembles sop/eop word streams into padded hash blocks
// (data, pad word, zero fill, message bit length) with block-level handshake.
module chu_pad_gen
  import chu_pad_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int LEN_W       = 64
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          in_val,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [2:0]                    in_alg,
  output logic                          in_rdy,
  output logic [BLOCK_WORDS*DATA_W-1:0] out_w,
  output logic [BLOCK_WORDS-1:0]        out_w_val,
  output logic                          out_blk_val,
  input  logic                          out_blk_rdy,
  output logic                          out_last,
  output logic [2:0]                    out_alg,
  output logic [7:0]                    mes_cnt,
  output logic                          err_sop
);

  localparam int LEN_WORDS = LEN_W / DATA_W;
  localparam int LEN_START = BLOCK_WORDS - LEN_WORDS;
  localparam int IDX_W     = $clog2(BLOCK_WORDS + 1);

  pad_state_e             state_q, state_d;
  pad_state_e             nxt_q, nxt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [2:0]             alg_q, alg_d;
  logic                   last_q, last_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                          accept;
  logic                          hs;
  logic                          len_fits;
  logic                          blk_full;
  logic [DATA_W-1:0]             pad_w;
  logic [BLOCK_WORDS-1:0]        wr_en;
  logic [BLOCK_WORDS*DATA_W-1:0] wr_data;
  logic                          wr_clr;

  assign in_rdy      = (state_q == ST_IDLE) || (state_q == ST_FILL);
  assign accept      = in_val && in_rdy;
  assign out_blk_val = (state_q == ST_EMIT);
  assign hs          = out_blk_val && out_blk_rdy;
  // idx_q is the first free slot once the message has ended.
  assign len_fits    = int'(idx_q) <= BLOCK_WORDS - 1 - LEN_WORDS;
  assign blk_full    = int'(idx_q) >= BLOCK_WORDS;
  assign pad_w       = DATA_W'(pad_word(alg_q, DATA_W));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      nxt_q  <= ST_IDLE;
      idx_q  <= '0;
      len_q  <= '0;
      alg_q  <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      nxt_q  <= nxt_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      alg_q  <= alg_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path through
  // this block leaves a value unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    alg_d   = alg_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept && in_sop) begin
          err_d   = (state_q == ST_FILL);
          alg_d   = in_alg;
          len_d   = LEN_W'(DATA_W);
          idx_d   = IDX_W'(1);
          state_d = in_eop ? ST_PAD : ST_FILL;
        end else if (accept && state_q == ST_FILL) begin
          len_d = len_q + LEN_W'(DATA_W);
          idx_d = idx_q + IDX_W'(1);
          if (in_eop) begin
            state_d = ST_PAD;
          end else if (idx_q == IDX_W'(BLOCK_WORDS - 1)) begin
            state_d = ST_EMIT;
            last_d  = 1'b0;
            nxt_d   = ST_FILL;
          end
        end
      end
      ST_PAD: begin
        state_d = ST_EMIT;
        last_d  = len_fits;
        if (len_fits)      nxt_d = ST_IDLE;
        else if (blk_full) nxt_d = ST_EXTRA_PAD;
        else               nxt_d = ST_EXTRA;
      end
      ST_EXTRA, ST_EXTRA_PAD: begin
        state_d = ST_EMIT;
        last_d  = 1'b1;
        nxt_d   = ST_IDLE;
      end
      ST_EMIT: begin
        if (out_blk_rdy) begin
          state_d = nxt_q;
          idx_d   = '0;
          last_d  = 1'b0;
          if (last_q) cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Block write port: data words while filling, pad/zero/length when closing.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    wr_clr  = hs || (state_q == ST_FILL && accept && in_sop);
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      unique case (state_q)
        ST_IDLE, ST_FILL: begin
          if (accept && (in_sop || state_q == ST_FILL) &&
              i == (in_sop ? 0 : int'(idx_q))) begin
            wr_en[i]                    = 1'b1;
            wr_data[i*DATA_W +: DATA_W] = in_data;
          end
        end
        ST_PAD: begin
          if (i >= int'(idx_q)) begin
            wr_en[i] = 1'b1;
            if (i == int'(idx_q))
              wr_data[i*DATA_W +: DATA_W] = pad_w;
            else if (len_fits && i >= LEN_START)
              wr_data[i*DATA_W +: DATA_W] =
                DATA_W'(len_word(alg_q, 128'(len_q), i - LEN_START, DATA_W, LEN_WORDS));
          end
        end
        ST_EXTRA, ST_EXTRA_PAD: begin
          wr_en[i] = 1'b1;
          if (i >= LEN_START)
            wr_data[i*DATA_W +: DATA_W] =
              DATA_W'(len_word(alg_q, 128'(len_q), i - LEN_START, DATA_W, LEN_WORDS));
          else if (i == 0 && state_q == ST_EXTRA_PAD)
            wr_data[i*DATA_W +: DATA_W] = pad_w;
        end
        default: ;
      endcase
    end
  end

  chu_pad_blk_reg #(
    .DATA_W      (DATA_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_blk_reg (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .we_i    (wr_en),
    .wdata_i (wr_data),
    .clr_i   (wr_clr),
    .data_o  (out_w),
    .val_o   (out_w_val)
  );

  assign out_last = last_q;
  assign out_alg  = alg_q;
  assign mes_cnt  = cnt_q;
  assign err_sop  = err_q;

endmodule

// File: tb/tb_chu_pad_gen.sv
// Self-checking bench for chu_pad_gen: directed table, latency/stall/error
// sequences and randomized traffic against a queue-based padding model.
module tb_chu_pad_gen;
  import chu_pad_pkg::*;

  localparam int DW = 32;
  localparam int BW = 16;
  localparam int LW = 64;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic              in_val, in_sop, in_eop;
  logic [DW-1:0]     in_data;
  logic [2:0]        in_alg;
  logic              in_rdy;
  logic [BW*DW-1:0]  out_w;
  logic [BW-1:0]     out_w_val;
  logic              out_blk_val, out_blk_rdy, out_last;
  logic [2:0]        out_alg;
  logic [7:0]        mes_cnt;
  logic              err_sop;

  always #5 sys_clk = ~sys_clk;

  chu_pad_gen #(.DATA_W(DW), .BLOCK_WORDS(BW), .LEN_W(LW)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_val      (in_val),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_data     (in_data),
    .in_alg      (in_alg),
    .in_rdy      (in_rdy),
    .out_w       (out_w),
    .out_w_val   (out_w_val),
    .out_blk_val (out_blk_val),
    .out_blk_rdy (out_blk_rdy),
    .out_last    (out_last),
    .out_alg     (out_alg),
    .mes_cnt     (mes_cnt),
    .err_sop     (err_sop)
  );

  typedef struct { logic [31:0] data; logic sop; logic eop; logic [2:0] alg; } in_t;
  typedef struct { logic [BW*DW-1:0] w; logic last; logic [2:0] alg; } blk_t;
  typedef struct { logic [2:0] alg; int n; int blk; int idx; logic [31:0] val;
                   logic last; int nblk; } vec_t;

  in_t  in_q[$];
  blk_t exp_q[$];
  blk_t got_q[$];
  vec_t vec[16];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  int   err_cnt = 0;

  always @(negedge sys_clk) if (err_sop === 1'b1) err_cnt++;

  task automatic check(input string name, input logic [639:0] got, input logic [639:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Padded message = data ++ pad ++ zeros up to 14 mod 16 ++ 64-bit length.
  task automatic model_msg(input logic [2:0] alg, input logic [31:0] ws[$]);
    logic [31:0] q[$];
    logic [63:0] bits;
    blk_t        b;
    q = ws;
    q.push_back(alg == ALG_MD5 ? 32'h0000_0080 : 32'h8000_0000);
    while (q.size() % 16 != 14) q.push_back(32'h0);
    bits = 64'(ws.size()) * 64'd32;
    if (alg == ALG_MD5) begin q.push_back(bits[31:0]);  q.push_back(bits[63:32]); end
    else                begin q.push_back(bits[63:32]); q.push_back(bits[31:0]);  end
    for (int b0 = 0; b0 < q.size(); b0 += 16) begin
      b.w = '0;
      for (int i = 0; i < 16; i++) b.w[i*32 +: 32] = q[b0 + i];
      b.last = (b0 + 16 == q.size());
      b.alg  = alg;
      exp_q.push_back(b);
    end
    exp_cnt++;
  endtask

  task automatic send_msg(input logic [2:0] alg, input int n, input bit rnd);
    logic [31:0] ws[$];
    in_t         t;
    for (int i = 0; i < n; i++) begin
      if (rnd)        ws.push_back($urandom);
      else if (i == 0) ws.push_back(32'h6162_6364);
      else            ws.push_back(32'(i));
    end
    for (int i = 0; i < n; i++) begin
      t.data = ws[i];
      t.sop  = (i == 0);
      t.eop  = (i == n - 1);
      t.alg  = (i == 0) ? alg : 3'($urandom_range(0, 7));
      in_q.push_back(t);
    end
    model_msg(alg, ws);
  endtask

  // One cycle, entered and left on a falling edge.
  task automatic step(input int val_pct, input int rdy_pct);
    blk_t e, g;
    out_blk_rdy = ($urandom_range(0, 99) < rdy_pct);
    if (in_q.size() != 0 && $urandom_range(0, 99) < val_pct) begin
      in_val  = 1'b1;
      in_data = in_q[0].data;
      in_sop  = in_q[0].sop;
      in_eop  = in_q[0].eop;
      in_alg  = in_q[0].alg;
      if (in_rdy) void'(in_q.pop_front());
    end else begin
      in_val  = 1'b0;
      in_sop  = 1'b0;
      in_eop  = 1'b0;
      in_data = $urandom;
      in_alg  = 3'($urandom_range(0, 7));
    end
    if (out_blk_val && out_blk_rdy) begin
      g.w = out_w; g.last = out_last; g.alg = out_alg;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL blk_unexpected: got block %0h with no block expected", out_w);
      end else begin
        e = exp_q.pop_front();
        check("block", {out_w, out_last, out_alg, out_w_val},
                       {e.w, e.last, e.alg, 16'hFFFF});
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic drain(input int vp, input int rp);
    int bud = 5000;
    while ((in_q.size() != 0 || exp_q.size() != 0) && bud > 0) begin
      step(vp, rp);
      bud--;
    end
    if (bud == 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d words, %0d blocks pending, need 0", in_q.size(), exp_q.size());
    end
  endtask

  initial begin
    logic [BW*DW:0] snap;
    int             sz, bud;
    bit             ok;
    blk_t           b;

    vec[0]  = '{ALG_SHA256, 1,  0, 0,  32'h6162_6364, 1'b1, 1};
    vec[1]  = '{ALG_SHA256, 1,  0, 1,  32'h8000_0000, 1'b1, 1};
    vec[2]  = '{ALG_SHA256, 1,  0, 8,  32'h0,         1'b1, 1};
    vec[3]  = '{ALG_SHA256, 1,  0, 15, 32'h20,        1'b1, 1};
    vec[4]  = '{ALG_MD5,    1,  0, 1,  32'h80,        1'b1, 1};
    vec[5]  = '{ALG_MD5,    1,  0, 14, 32'h20,        1'b1, 1};
    vec[6]  = '{ALG_MD5,    1,  0, 15, 32'h0,         1'b1, 1};
    vec[7]  = '{ALG_SHA1,   14, 0, 14, 32'h8000_0000, 1'b0, 2};
    vec[8]  = '{ALG_SHA1,   14, 0, 15, 32'h0,         1'b0, 2};
    vec[9]  = '{ALG_SHA1,   14, 1, 0,  32'h0,         1'b1, 2};
    vec[10] = '{ALG_SHA1,   14, 1, 15, 32'h1C0,       1'b1, 2};
    vec[11] = '{ALG_SHA512, 16, 0, 15, 32'hF,         1'b0, 2};
    vec[12] = '{ALG_SHA512, 16, 1, 0,  32'h8000_0000, 1'b1, 2};
    vec[13] = '{ALG_SHA512, 16, 1, 15, 32'h200,       1'b1, 2};
    vec[14] = '{ALG_MD5,    13, 0, 14, 32'h1A0,       1'b1, 1};
    vec[15] = '{ALG_MD5,    15, 1, 14, 32'h1E0,       1'b1, 2};

    in_val = 0; in_sop = 0; in_eop = 0; in_data = 0; in_alg = 0; out_blk_rdy = 0;
    #1 sys_rst = 1'b1;
    #2;
    check("rst_outputs", {in_rdy, out_w, out_w_val, out_blk_val, out_last, out_alg, mes_cnt, err_sop},
                         {1'b1, {(BW*DW){1'b0}}, 16'h0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0});
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Single-block latency: eop cycle t, block valid at t+2.
    send_msg(ALG_SHA256, 1, 0);
    step(100, 100);
    check("lat1_pad_cycle", {out_blk_val, in_rdy}, 2'b00);
    step(100, 100);
    check("lat1_emit_cycle", out_blk_val, 1'b1);
    drain(100, 100);
    check("lat1_mes_cnt", mes_cnt, 8'd1);

    // Two-block latency: second block valid at t+4 with rdy held high.
    send_msg(ALG_SHA256, 14, 0);
    repeat (14) step(100, 100);
    check("lat2_pad_cycle", out_blk_val, 1'b0);
    step(100, 100);
    check("lat2_blk1", out_blk_val, 1'b1);
    step(100, 100);
    check("lat2_extra_cycle", out_blk_val, 1'b0);
    step(100, 100);
    check("lat2_blk2", {out_blk_val, out_last}, 2'b11);
    drain(100, 100);

    for (int k = 0; k < 16; k++) begin
      got_q.delete();
      send_msg(vec[k].alg, vec[k].n, 0);
      drain(100, 100);
      check($sformatf("tbl%0d_nblk", k), got_q.size(), vec[k].nblk);
      if (got_q.size() > vec[k].blk) begin
        b = got_q[vec[k].blk];
        check($sformatf("tbl%0d_word", k), {b.w[vec[k].idx*32 +: 32], b.last},
                                           {vec[k].val, vec[k].last});
      end else begin
        n_tests++; n_fail++;
        $display("FAIL tbl%0d_word: got %0d blocks, need block %0d", k, got_q.size(), vec[k].blk);
      end
    end
    check("tbl_mes_cnt", mes_cnt, 8'(exp_cnt));

    // sop inside a message: partial message A dropped, B padded alone.
    err_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      in_q.push_back('{32'hA000_0000 + 32'(i), (i == 0), 1'b0, ALG_SHA256});
    end
    send_msg(ALG_SHA1, 3, 1);
    drain(100, 100);
    check("err_sop_pulses", err_cnt, 1);
    check("err_mes_cnt", mes_cnt, 8'(exp_cnt));

    // Consumer stall: block held, no input taken.
    send_msg(ALG_SHA256, 1, 1);
    send_msg(ALG_MD5, 3, 1);
    bud = 20;
    while (!out_blk_val && bud > 0) begin step(100, 0); bud--; end
    check("stall_reach", out_blk_val, 1'b1);
    snap = {out_w, out_last};
    sz   = in_q.size();
    ok   = 1'b1;
    repeat (10) begin
      step(100, 0);
      if ({out_w, out_last} !== snap || in_rdy !== 1'b0 || out_blk_val !== 1'b1) ok = 1'b0;
    end
    check("stall_stable", ok, 1'b1);
    check("stall_no_take", in_q.size(), sz);
    drain(100, 100);

    // Random traffic with gaps, backpressure and stray non-sop words.
    err_cnt = 0;
    for (int m = 0; m < 30; m++) begin
      if ($urandom_range(0, 4) == 0)
        in_q.push_back('{$urandom, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))});
      send_msg(3'($urandom_range(0, 3)), $urandom_range(1, 40), 1);
    end
    drain(70, 60);
    check("rand_mes_cnt", mes_cnt, 8'(exp_cnt));
    check("rand_no_err", err_cnt, 0);

    // Message counter wrap.
    for (int m = 0; m < 260; m++) send_msg(3'($urandom_range(0, 3)), 1, 1);
    drain(100, 100);
    check("wrap_mes_cnt", mes_cnt, 8'(exp_cnt));

    // Async reset in the middle of FILL.
    for (int i = 0; i < 5; i++) in_q.push_back('{$urandom, (i == 0), (i == 4), ALG_SHA256});
    repeat (3) step(100, 100);
    check("pre_rst_wval", out_w_val, 16'h0007);
    #2;
    sys_rst = 1'b1;
    in_val  = 1'b0;
    in_q.delete();
    #1;
    check("mid_rst_outputs", {in_rdy, out_w, out_w_val, out_blk_val, mes_cnt},
                             {1'b1, {(BW*DW){1'b0}}, 16'h0, 1'b0, 8'd0});
    @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_cnt = 0;
    send_msg(ALG_MD5, 5, 1);
    drain(100, 100);
    check("post_rst_mes_cnt", mes_cnt, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
